// File: rtl/fact_share_arbiter_pkg.sv
// Shared types and helpers for the factorial-unit sharing arbiter.
// State encoding matches the compiled unit's wrapper so traces line up.
package fact_share_arbiter_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_ISSUE = 2'd1,
        ARB_WAIT  = 2'd2,
        ARB_RESP  = 2'd3
    } arb_state_t;

    localparam int INT_N = 16;

    // Position reached by stepping 'offset' places past 'base' on a ring of n.
    function automatic int rr_index(input int base, input int offset, input int n);
        return (base + offset) % n;
    endfunction

endpackage

// File: rtl/fact_share_arbiter_rr_pick.sv
// Combinational round-robin select: first asserted request after ptr, wrapping.
module rr_pick
    import fact_share_arbiter_pkg::*;
#(
    parameter int N  = 4,
    parameter int IW = 3
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic          grant_valid,
    output logic [IW-1:0] grant_idx
);

    // Walk from the farthest offset to the nearest so the nearest hit wins.
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        for (int k = N; k >= 1; k--) begin
            for (int i = 0; i < N; i++) begin
                if (req[i] && (rr_index(int'(ptr), k, N) == i)) begin
                    grant_valid = 1'b1;
                    grant_idx   = IW'(i);
                end
            end
        end
    end

endmodule

// File: rtl/fact_share_arbiter.sv
// Shares one handshake compute unit among N requesters, one transaction at a time,
// with round-robin acceptance and results routed back to the issuing requester.
module fact_share_arbiter
    import fact_share_arbiter_pkg::*;
#(
    parameter int N  = 4,
    parameter int W  = INT_N,
    parameter int IW = 3
) (
    input  logic           clk,
    input  logic           nrst,
    input  logic [N-1:0]   req_in_valid,
    output logic [N-1:0]   req_in_ready,
    input  logic [N*W-1:0] req_in0,
    output logic [N-1:0]   req_out_valid,
    input  logic [N-1:0]   req_out_ready,
    output logic [N*W-1:0] req_out0,
    output logic           unit_in_valid,
    input  logic           unit_in_ready,
    output logic [W-1:0]   unit_in0,
    input  logic           unit_out_valid,
    output logic           unit_out_ready,
    input  logic [W-1:0]   unit_out0,
    output logic           busy,
    output logic [IW-1:0]  owner
);

    arb_state_t    state_reg;
    logic [IW-1:0] ptr_reg;
    logic [IW-1:0] owner_reg;
    logic [W-1:0]  operand_reg;
    logic [W-1:0]  result_reg;

    logic          grant_valid;
    logic [IW-1:0] grant_idx;
    logic [N-1:0]  grant_onehot;
    logic [N-1:0]  owner_onehot;
    logic [W-1:0]  grant_operand;
    logic          consume;

    rr_pick #(
        .N  (N),
        .IW (IW)
    ) u_pick (
        .req         (req_in_valid),
        .ptr         (ptr_reg),
        .grant_valid (grant_valid),
        .grant_idx   (grant_idx)
    );

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_lane
            assign grant_onehot[gi]     = grant_valid && (grant_idx == IW'(gi));
            assign owner_onehot[gi]     = (owner_reg == IW'(gi));
            assign req_out0[gi*W +: W]  = req_out_valid[gi] ? result_reg : '0;
        end
    endgenerate

    always_comb begin
        grant_operand = '0;
        for (int i = 0; i < N; i++) begin
            if (grant_onehot[i]) grant_operand = req_in0[i*W +: W];
        end
    end

    // Acceptance is combinational; gating with nrst keeps it quiet during reset.
    assign req_in_ready   = (nrst && state_reg == ARB_IDLE) ? grant_onehot : '0;
    assign req_out_valid  = (state_reg == ARB_RESP) ? owner_onehot : '0;
    assign consume        = |(req_out_valid & req_out_ready);
    assign unit_in_valid  = (state_reg == ARB_ISSUE);
    assign unit_in0       = operand_reg;
    assign unit_out_ready = (state_reg == ARB_WAIT);
    assign busy           = (state_reg != ARB_IDLE);
    assign owner          = owner_reg;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_reg   <= ARB_IDLE;
            ptr_reg     <= IW'(N - 1);
            owner_reg   <= '0;
            operand_reg <= '0;
            result_reg  <= '0;
        end else begin
            case (state_reg)
                ARB_IDLE: begin
                    if (grant_valid) begin
                        operand_reg <= grant_operand;
                        owner_reg   <= grant_idx;
                        state_reg   <= ARB_ISSUE;
                    end
                end
                ARB_ISSUE: begin
                    if (unit_in_ready) state_reg <= ARB_WAIT;
                end
                ARB_WAIT: begin
                    if (unit_out_valid) begin
                        result_reg <= unit_out0;
                        state_reg  <= ARB_RESP;
                    end
                end
                ARB_RESP: begin
                    // Last owner becomes lowest priority for the next pick.
                    if (consume) begin
                        ptr_reg   <= owner_reg;
                        owner_reg <= '0;
                        state_reg <= ARB_IDLE;
                    end
                end
                default: state_reg <= ARB_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fact_share_arbiter.sv
// Scoreboard bench for fact_share_arbiter with a behavioural factorial unit stand-in.
module tb_fact_share_arbiter;
    localparam int N  = 4;
    localparam int W  = 16;
    localparam int IW = 3;

    logic           clk = 1'b0;
    logic           nrst = 1'b0;
    logic [N-1:0]   req_in_valid, req_in_ready, req_out_valid, req_out_ready;
    logic [N*W-1:0] req_in0, req_out0;
    logic           unit_in_valid, unit_in_ready, unit_out_valid, unit_out_ready;
    logic [W-1:0]   unit_in0, unit_out0;
    logic           busy;
    logic [IW-1:0]  owner;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    fact_share_arbiter #(.N(N), .W(W), .IW(IW)) dut (
        .clk(clk), .nrst(nrst),
        .req_in_valid(req_in_valid), .req_in_ready(req_in_ready), .req_in0(req_in0),
        .req_out_valid(req_out_valid), .req_out_ready(req_out_ready), .req_out0(req_out0),
        .unit_in_valid(unit_in_valid), .unit_in_ready(unit_in_ready), .unit_in0(unit_in0),
        .unit_out_valid(unit_out_valid), .unit_out_ready(unit_out_ready), .unit_out0(unit_out0),
        .busy(busy), .owner(owner)
    );

    task automatic check(input bit ok, input string name, input longint act, input longint exp);
        vectors++;
        if (!ok) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [W-1:0] fact16(input logic [W-1:0] n);
        logic [W-1:0] r = 1;
        if (n >= 18) return '0;
        for (int k = 2; k <= int'(n); k++) r = r * W'(k);
        return r;
    endfunction

    // Reference arbitration: first valid requester after the last completed owner.
    function automatic logic [N-1:0] rr_expect(input logic [N-1:0] v, input int last);
        for (int k = 1; k <= N; k++)
            if (v[(last + k) % N]) return N'(1) << ((last + k) % N);
        return '0;
    endfunction

    // ---------------- factorial unit stand-in ----------------
    logic         unit_busy, unit_rdy_rand, unit_stall;
    logic [W-1:0] unit_res;
    int           unit_lat;
    int           unit_issues = 0;

    assign unit_in_ready = !unit_busy && !unit_stall && unit_rdy_rand;

    always @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            unit_busy <= 1'b0; unit_out_valid <= 1'b0; unit_out0 <= '0;
            unit_lat <= 0; unit_res <= '0; unit_rdy_rand <= 1'b1;
        end else begin
            unit_rdy_rand <= ($urandom_range(0, 3) != 0);
            if (!unit_busy && unit_in_valid && unit_in_ready) begin
                unit_busy   <= 1'b1;
                unit_lat    <= $urandom_range(0, 3);
                unit_res    <= fact16(unit_in0);
                unit_issues <= unit_issues + 1;
            end else if (unit_busy && !unit_out_valid) begin
                if (unit_lat == 0) begin
                    unit_out_valid <= 1'b1;
                    unit_out0      <= unit_res;
                end else unit_lat <= unit_lat - 1;
            end else if (unit_out_valid && unit_out_ready) begin
                unit_out_valid <= 1'b0;
                unit_busy      <= 1'b0;
            end
        end
    end

    // ---------------- scoreboard ----------------
    typedef struct { int idx; logic [W-1:0] val; } txn_t;
    txn_t         exp_q[$];
    int           model_ptr = N - 1;
    logic [N-1:0] acc = '0;
    int           grant_hist [256];
    int           grant_cnt = 0;
    int           done_cnt = 0;
    int           last_res [N];

    // Input side: grant model and expectation push at acceptance.
    logic         prev_stall = 1'b0;
    logic [W-1:0] prev_in0 = '0;
    logic [N-1:0] exp_rdy;
    int           gidx;
    always @(negedge clk) begin
        if (!nrst) begin
            check(req_in_ready == 0 && req_out_valid == 0 && !unit_in_valid && !unit_out_ready
                  && !busy && owner == 0 && req_out0 == 0, "reset_outputs",
                  {busy, req_in_ready, req_out_valid}, 0);
            prev_stall = 1'b0;
            acc = '0;
        end else begin
            acc = req_in_valid & req_in_ready;
            if (!busy) begin
                exp_rdy = rr_expect(req_in_valid, model_ptr);
                if (req_in_valid != 0 || req_in_ready != 0)
                    check(req_in_ready == exp_rdy, "grant", req_in_ready, exp_rdy);
                check(owner == 0, "owner_idle", owner, 0);
            end else begin
                check(req_in_ready == 0, "ready_while_busy", req_in_ready, 0);
            end
            if (prev_stall)
                check(unit_in_valid && unit_in0 == prev_in0, "issue_hold", unit_in0, prev_in0);
            prev_stall = unit_in_valid && !unit_in_ready;
            prev_in0   = unit_in0;
            if (acc != 0) begin
                gidx = 0;
                for (int i = 0; i < N; i++) if (acc[i]) gidx = i;
                exp_q.push_back('{gidx, fact16(req_in0[gidx*W +: W])});
                grant_hist[grant_cnt % 256] = gidx;
                grant_cnt++;
            end
        end
    end

    // Output side: pop and compare whenever a result is consumed.
    logic         prev_hold = 1'b0, prev_consume = 1'b0;
    logic [N-1:0] prev_ov, cons;
    logic [N*W-1:0] prev_o0;
    logic [W-1:0] got;
    int           oidx;
    txn_t         e;
    always @(negedge clk) begin
        if (!nrst) begin
            exp_q.delete();
            model_ptr    = N - 1;
            prev_hold    = 1'b0;
            prev_consume = 1'b0;
        end else begin
            if (prev_consume) check(!busy, "busy_after_consume", busy, 0);
            if (prev_hold)
                check(req_out_valid == prev_ov && req_out0 == prev_o0, "resp_hold", req_out_valid, prev_ov);
            cons = req_out_valid & req_out_ready;
            if (req_out_valid != 0) begin
                check($onehot(req_out_valid), "out_onehot", req_out_valid, 0);
                oidx = 0;
                for (int i = 0; i < N; i++) if (req_out_valid[i]) oidx = i;
                check(int'(owner) == oidx, "owner_resp", owner, oidx);
                if (cons != 0) begin
                    got = req_out0[oidx*W +: W];
                    if (exp_q.size() == 0) begin
                        check(1'b0, "unexpected_result", oidx, -1);
                    end else begin
                        e = exp_q.pop_front();
                        check(oidx == e.idx, "result_owner", oidx, e.idx);
                        check(got == e.val, "result_value", got, e.val);
                    end
                    $display("txn %0d: requester %0d result %0d", done_cnt, oidx, got);
                    last_res[oidx] = int'(got);
                    done_cnt++;
                    model_ptr = oidx;
                end
            end
            prev_hold    = (req_out_valid != 0) && (cons == 0);
            prev_ov      = req_out_valid;
            prev_o0      = req_out0;
            prev_consume = (cons != 0);
        end
    end

    // ---------------- stimulus ----------------
    logic [N-1:0] hold_mode = '0;
    bit           rand_en = 1'b0;

    task automatic cyc();
        @(posedge clk); #1;
        for (int i = 0; i < N; i++) begin
            if (acc[i] && !hold_mode[i]) req_in_valid[i] = 1'b0;
            if (rand_en) begin
                if (!req_in_valid[i] && $urandom_range(0, 3) == 0) begin
                    req_in_valid[i] = 1'b1;
                    req_in0[i*W +: W] = W'($urandom_range(0, 20));
                end else if (req_in_valid[i] && !acc[i] && $urandom_range(0, 15) == 0) begin
                    req_in_valid[i] = 1'b0;
                end
            end
        end
        if (rand_en) begin
            req_out_ready = N'($urandom);
            unit_stall    = ($urandom_range(0, 4) == 0);
        end
    endtask

    task automatic send(input int i, input int op);
        req_in0[i*W +: W] = W'(op);
        req_in_valid[i]   = 1'b1;
    endtask

    task automatic wait_done(input int target, input string name);
        int n = 0;
        while (done_cnt < target && n < 300) begin cyc(); n++; end
        check(done_cnt >= target, name, done_cnt, target);
    endtask

    task automatic do_reset();
        nrst = 1'b0;
        repeat (2) cyc();
        nrst = 1'b1;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
        $fatal(1);
    end

    int base, g0, i0, n;
    initial begin
        req_in_valid = '0; req_in0 = '0; req_out_ready = '0; unit_stall = 1'b0;
        for (int i = 0; i < N; i++) last_res[i] = -1;
        repeat (3) cyc();
        nrst = 1'b1;
        req_out_ready = '1;

        // single request
        base = done_cnt;
        send(0, 8);
        wait_done(base + 1, "single_timeout");
        check(last_res[0] == 40320, "single_value", last_res[0], 40320);

        // simultaneous from reset
        do_reset();
        base = done_cnt; g0 = grant_cnt;
        send(0, 3); send(1, 5); send(2, 0); send(3, 7);
        wait_done(base + 4, "simul_timeout");
        for (int k = 0; k < 4; k++)
            check(grant_hist[(g0 + k) % 256] == k, "simul_order", grant_hist[(g0 + k) % 256], k);
        check(last_res[0] == 6, "simul_r0", last_res[0], 6);
        check(last_res[1] == 120, "simul_r1", last_res[1], 120);
        check(last_res[2] == 1, "simul_r2", last_res[2], 1);
        check(last_res[3] == 5040, "simul_r3", last_res[3], 5040);

        // fairness with two persistent requesters
        base = done_cnt; g0 = grant_cnt;
        hold_mode[1] = 1'b1; hold_mode[2] = 1'b1;
        send(1, 4); send(2, 4);
        wait_done(base + 4, "fair_timeout");
        hold_mode = '0; req_in_valid = '0;
        n = 0; while (busy && n < 100) begin cyc(); n++; end
        for (int k = 0; k < 4; k++)
            check(grant_hist[(g0 + k) % 256] == ((k % 2 == 0) ? 1 : 2), "fair_order",
                  grant_hist[(g0 + k) % 256], (k % 2 == 0) ? 1 : 2);
        check(last_res[1] == 24 && last_res[2] == 24, "fair_value", last_res[1], 24);

        // result backpressure
        base = done_cnt;
        req_out_ready = '1; req_out_ready[0] = 1'b0;
        send(0, 6);
        n = 0; while (!req_out_valid[0] && n < 100) begin cyc(); n++; end
        check(req_out_valid[0], "bp_reach_resp", req_out_valid, 1);
        send(1, 3);
        repeat (10) cyc();
        check(req_out_valid[0] && req_out0[0 +: W] == 720, "bp_hold_value", req_out0[0 +: W], 720);
        check(req_in_ready == 0, "bp_no_ready", req_in_ready, 0);
        req_out_ready[0] = 1'b1;
        wait_done(base + 2, "bp_timeout");
        check(last_res[0] == 720, "bp_value", last_res[0], 720);
        check(last_res[1] == 6, "bp_next_value", last_res[1], 6);

        // unit stall in ISSUE
        base = done_cnt;
        unit_stall = 1'b1;
        send(2, 5);
        n = 0; while (!unit_in_valid && n < 100) begin cyc(); n++; end
        i0 = unit_issues;
        repeat (5) cyc();
        check(unit_in_valid && unit_in0 == 5, "stall_hold", unit_in0, 5);
        check(unit_issues == i0, "stall_no_issue", unit_issues, i0);
        unit_stall = 1'b0;
        wait_done(base + 1, "stall_timeout");
        check(unit_issues == i0 + 1, "stall_single_issue", unit_issues, i0 + 1);
        check(last_res[2] == 120, "stall_value", last_res[2], 120);

        // reset while waiting on the unit
        send(3, 7);
        n = 0; while (!unit_out_ready && n < 100) begin cyc(); n++; end
        check(unit_out_ready, "rst_reach_wait", unit_out_ready, 1);
        nrst = 1'b0;
        #1;
        check(!busy && !unit_out_ready && !unit_in_valid && req_out_valid == 0 && req_in_ready == 0
              && owner == 0, "async_reset", busy, 0);
        repeat (2) cyc();
        nrst = 1'b1;
        base = done_cnt;
        send(0, 2);
        wait_done(base + 1, "post_reset_timeout");
        check(last_res[0] == 2, "post_reset_value", last_res[0], 2);

        // randomized traffic
        rand_en = 1'b1;
        repeat (3000) cyc();
        rand_en = 1'b0;
        req_in_valid = '0; req_out_ready = '1; unit_stall = 1'b0;
        n = 0; while (busy && n < 200) begin cyc(); n++; end
        cyc();
        check(!busy, "drain_idle", busy, 0);
        check(exp_q.size() == 0, "drain_empty", exp_q.size(), 0);
        check(unit_issues == grant_cnt, "issue_count", unit_issues, grant_cnt);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/fact_share_arbiter.md
Name: fact_share_arbiter

Overview:
- Shares one sync-handshake compute unit (a compiled `tests_fact` instance) between N independent requesters.
- Accepts one operand at a time with round-robin fairness, issues it to the unit, waits for the result, and returns the result only to the requester that issued it.
- Sits between requester logic and the single compiled function instance, so one unit serves many callers.

Parameters:
- N, 4, number of requesters (2..8).
- W, `intN (16), operand/result width.
- IW, 3, width of owner index; must satisfy 2**IW >= N.

Ports:
- clk  input  1  clock, rising edge.
- nrst  input  1  asynchronous active-low reset.
- req_in_valid  input  N  per-requester operand valid.
- req_in_ready  output  N  per-requester operand accepted (one-hot or zero).
- req_in0  input  N*W  operands; requester i at bits [i*W +: W].
- req_out_valid  output  N  per-requester result valid (one-hot or zero).
- req_out_ready  input  N  per-requester result consume.
- req_out0  output  N*W  results; slice i is valid only while req_out_valid[i].
- unit_in_valid  output  1  to unit in_valid.
- unit_in_ready  input  1  from unit in_ready.
- unit_in0  output  W  to unit in0.
- unit_out_valid  input  1  from unit out_valid.
- unit_out_ready  output  1  to unit out_ready.
- unit_out0  input  W  from unit out0.
- busy  output  1  high in any state except IDLE.
- owner  output  IW  index of current transaction owner (0 in IDLE).

Behaviour:
- Reset (nrst low, async):
  - state=IDLE, ptr=N-1, owner=0, operand and result regs=0.
  - All valid and ready outputs 0; busy=0.
- States are IDLE, ISSUE, WAIT and RESP.
- IDLE:
  - g = first index i with req_in_valid[i], searching ptr+1, ptr+2, ... with wrap modulo N.
  - req_in_ready[g]=1 combinationally (Mealy); no other ready is asserted.
  - On the clock edge with a winner: operand<=req_in0[g], owner<=g, go to ISSUE.
  - With no valid request, stay in IDLE.
- ISSUE:
  - unit_in_valid=1 and unit_in0=operand.
  - When unit_in_ready=1 at the edge, go to WAIT; otherwise hold the outputs stable.
- WAIT:
  - unit_out_ready=1.
  - When unit_out_valid=1 at the edge: result<=unit_out0, go to RESP.
- RESP:
  - req_out_valid[owner]=1 and the req_out0 slice for owner = result.
  - On req_out_ready[owner]=1: ptr<=owner, go to IDLE.
  - Ready signals from non-owners are ignored.
- Exactly one transaction is in flight at a time; all req_in_ready are 0 outside IDLE.
- Latency, best case:
  - accept edge, then 1 cycle ISSUE, then unit latency, then 1 cycle into RESP.
  - If req_out_ready is already high in RESP, the next accept happens in the following IDLE cycle (2 cycles of overhead per transaction).
- Fairness: after owner k completes, requester k has the lowest priority. A continuously asserting requester waits at most N-1 transactions.
- Simultaneous requests: the round-robin pick alone decides; losers keep valid asserted and are not dropped.
- A requester that deasserts req_in_valid before being granted is simply skipped.
- Reset mid-transaction: the arbiter returns to IDLE immediately and discards the in-flight result. The unit shares the same nrst and also resets, so no stale unit_out_valid arrives afterwards.
- Widths: arithmetic on ptr/owner is modulo N; indices >= N are never produced. Results pass through unmodified (unit overflow is the unit's concern).

Decomposition:
- Shared include, next to primitives.v:
  - state encodings (ARB_IDLE=0, ARB_ISSUE=1, ARB_WAIT=2, ARB_RESP=3);
  - uses `intN, `intT, `true and `false from primitives.v.
- Sub-module rr_pick (N, IW): combinational round-robin select.
  - Inputs: req[N], ptr[IW].
  - Outputs: grant_valid, grant_idx[IW].
  - Instantiated once.
- The bench instantiates the real tests_fact via `inst_sync` and wires it to the unit_* ports.

Test Plan:
- Single request: req 0 sends 8 → req_out_valid[0] rises with req_out0 slice 0 = 40320; all other out_valid stay 0; busy falls one cycle after consume.
- Simultaneous: reqs 0..3 all valid with 3, 5, 0, 7 from reset (ptr=N-1) → grant order 0, 1, 2, 3; results 6, 120, 1, 5040, each on the correct slice.
- Fairness: reqs 1 and 2 held valid continuously with 4 → grants alternate 1, 2, 1, 2; neither waits more than one transaction.
- Backpressure: hold req_out_ready[0]=0 for 10 cycles in RESP → out_valid and the 720 result (input 6) stay stable; no new req_in_ready is issued; the transaction completes on release.
- Unit stall: force unit_in_ready low for 5 cycles in ISSUE → unit_in_valid and unit_in0 held constant; no double issue.
- Reset mid-WAIT: drop nrst during WAIT → all outputs 0 asynchronously, state IDLE; after release a new request for 2 returns 2.
